tdc_cal_ctrl: RTL and testbench

Calibration sequencer for the 64-stage, 6-bit delay-line TDC in the phase-sync PLL loop. On request it releases the TDC reset and waits for settling. It then averages 2^LOG2N consecutive TDC codes, each measuring one full DCO period in delay-cell units, and computes the normalisation gain KTDC as the DCO period per TDC LSB. KTDC and the averaged period feed the digital loop filter and phase-error scaling.

---
 rtl/tdc_cal_pkg.sv | 30 +++
 rtl/tdc_cal_if.sv | 28 ++
 rtl/tdc_cal_div.sv | 84 ++++++++
 rtl/tdc_cal_ctrl.sv | 150 +++++++++++++++
 tb/tb_tdc_cal_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tdc_cal_pkg.sv
// Shared types and constants for the TDC calibration sequencer.
// Holds the FSM state encoding, default parameters and the saturated TDC codes.
package tdc_cal_pkg;

   localparam int DEF_LOG2N  = 4;
   localparam int DEF_SETTLE = 8;
   localparam int DEF_FRACW  = 4;
   localparam int DEF_GAINW  = 12;
   localparam int DEF_MINP   = 4;

   localparam int CODEW = 6;

   localparam logic [CODEW-1:0] CODE_SAT_LO = 6'd0;
   localparam logic [CODEW-1:0] CODE_SAT_HI = 6'd63;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_ACCUM,
      ST_AVG,
      ST_DIV,
      ST_DONE
   } cal_state_t;

   // A code pinned at either end of the delay line means the edge fell outside it.
   function automatic logic is_sat_code(input logic [CODEW-1:0] c);
      return (c == CODE_SAT_LO) || (c == CODE_SAT_HI);
   endfunction

endpackage

// File: rtl/tdc_cal_if.sv
// Calibration request / TDC code / result bundle between the PLL control and the sequencer.
interface tdc_cal_if
   import tdc_cal_pkg::*;
#(
   parameter int FRACW = DEF_FRACW,
   parameter int GAINW = DEF_GAINW
) ();

   logic                   start;
   logic [CODEW-1:0]       code;
   logic                   tdc_nrst;
   logic                   busy;
   logic                   done;
   logic                   err;
   logic [CODEW+FRACW-1:0] period;
   logic [GAINW-1:0]       ktdc;

   modport master (
      output start, code,
      input  tdc_nrst, busy, done, err, period, ktdc
   );

   modport slave (
      input  start, code,
      output tdc_nrst, busy, done, err, period, ktdc
   );

endinterface

// File: rtl/tdc_cal_div.sv
// Restoring serial divider, one quotient bit per cycle, quotient saturated to QW bits.
// The first bit is resolved on the go edge so the result is ready DVDW cycles after go.
module tdc_cal_div #(
   parameter int DVDW = 17,
   parameter int DSRW = 10,
   parameter int QW   = 12
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_go,
   input  logic [DVDW-1:0] i_dividend,
   input  logic [DSRW-1:0] i_divisor,
   output logic [QW-1:0]   o_quotient,
   output logic            o_valid
);

   localparam int CNTW = $clog2(DVDW + 1);

   logic [DSRW-1:0] r_rem;
   logic [DSRW-1:0] r_dsr;
   logic [DVDW-1:0] r_dvd;
   logic [DVDW-1:0] r_q;
   logic [CNTW-1:0] r_cnt;
   logic            r_run;
   logic            r_valid;

   logic [DSRW-1:0] w_rem_src;
   logic [DSRW-1:0] w_dsr_src;
   logic [DVDW-1:0] w_dvd_src;
   logic [DVDW-1:0] w_q_src;
   logic [DSRW:0]   w_trial;
   logic [DSRW:0]   w_diff;
   logic            w_ge;
   logic [DSRW-1:0] w_rem_nxt;
   logic [DVDW-1:0] w_dvd_nxt;
   logic [DVDW-1:0] w_q_nxt;

   assign w_rem_src = i_go ? '0 : r_rem;
   assign w_dsr_src = i_go ? i_divisor : r_dsr;
   assign w_dvd_src = i_go ? i_dividend : r_dvd;
   assign w_q_src   = i_go ? '0 : r_q;

   assign w_trial   = {w_rem_src, w_dvd_src[DVDW-1]};
   assign w_diff    = w_trial - {1'b0, w_dsr_src};
   assign w_ge      = (w_trial >= {1'b0, w_dsr_src});
   assign w_rem_nxt = w_ge ? w_diff[DSRW-1:0] : w_trial[DSRW-1:0];
   assign w_q_nxt   = {w_q_src[DVDW-2:0], w_ge};
   assign w_dvd_nxt = {w_dvd_src[DVDW-2:0], 1'b0};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rem   <= '0;
         r_dsr   <= '0;
         r_dvd   <= '0;
         r_q     <= '0;
         r_cnt   <= '0;
         r_run   <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (i_go) begin
            r_rem <= w_rem_nxt;
            r_dvd <= w_dvd_nxt;
            r_q   <= w_q_nxt;
            r_dsr <= i_divisor;
            r_cnt <= CNTW'(DVDW - 1);
            r_run <= 1'b1;
         end else if (r_run) begin
            r_rem <= w_rem_nxt;
            r_dvd <= w_dvd_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt - CNTW'(1);
            if (r_cnt == CNTW'(1)) begin
               r_run   <= 1'b0;
               r_valid <= 1'b1;
            end
         end
      end
   end

   assign o_quotient = (|r_q[DVDW-1:QW]) ? '1 : r_q[QW-1:0];
   assign o_valid    = r_valid;

endmodule

// File: rtl/tdc_cal_ctrl.sv
// TDC calibration sequencer: releases TDC reset, settles, averages 2^LOG2N codes
// and derives KTDC = 2^(GAINW+FRACW) / PERIOD for the loop filter.
module tdc_cal_ctrl
   import tdc_cal_pkg::*;
#(
   parameter int LOG2N  = DEF_LOG2N,
   parameter int SETTLE = DEF_SETTLE,
   parameter int FRACW  = DEF_FRACW,
   parameter int GAINW  = DEF_GAINW,
   parameter int MINP   = DEF_MINP
) (
   input  logic     i_clk,
   input  logic     i_rst,
   tdc_cal_if.slave cal
);

   localparam int ACCW   = CODEW + LOG2N;
   localparam int PERW   = CODEW + FRACW;
   localparam int DVDW   = GAINW + FRACW + 1;
   localparam int NSAMP  = 1 << LOG2N;
   localparam int CNTMAX = (SETTLE > NSAMP) ? SETTLE : NSAMP;
   localparam int CNTW   = $clog2(CNTMAX + 1);

   localparam logic [PERW-1:0] MIN_AVG     = PERW'(MINP << FRACW);
   localparam logic [DVDW-1:0] DIVIDEND    = {1'b1, {(DVDW-1){1'b0}}};
   localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'(SETTLE - 1);
   localparam logic [CNTW-1:0] ACCUM_LAST  = CNTW'(NSAMP - 1);

   cal_state_t      r_state;
   logic            r_start;
   logic [CNTW-1:0] r_cnt;
   logic [ACCW-1:0] r_sum;
   logic            r_sat;
   logic            r_tdc_nrst;
   logic            r_busy;
   logic            r_done;
   logic            r_err;
   logic [PERW-1:0] r_period;
   logic [GAINW-1:0] r_ktdc;

   logic [PERW-1:0]  w_avg;
   logic             w_fail;
   logic             w_div_go;
   logic             w_div_valid;
   logic [GAINW-1:0] w_quot;

   // r_sum is frozen from AVG through DONE, so w_avg is still the right PERIOD at DONE.
   assign w_avg    = PERW'(r_sum) << (FRACW - LOG2N);
   assign w_fail   = r_sat || (w_avg < MIN_AVG);
   assign w_div_go = (r_state == ST_AVG) && !w_fail;

   tdc_cal_div #(
      .DVDW (DVDW),
      .DSRW (PERW),
      .QW   (GAINW)
   ) u_div (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_go       (w_div_go),
      .i_dividend (DIVIDEND),
      .i_divisor  (w_avg),
      .o_quotient (w_quot),
      .o_valid    (w_div_valid)
   );

   // START is qualified with IDLE when sampled, so a request in the DONE cycle is dropped.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_start    <= 1'b0;
         r_cnt      <= '0;
         r_sum      <= '0;
         r_sat      <= 1'b0;
         r_tdc_nrst <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_period   <= '0;
         r_ktdc     <= '0;
      end else begin
         r_start <= cal.start && (r_state == ST_IDLE);
         r_done  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (r_start) begin
                  r_err      <= 1'b0;
                  r_sum      <= '0;
                  r_cnt      <= '0;
                  r_sat      <= 1'b0;
                  r_tdc_nrst <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (r_cnt == SETTLE_LAST) begin
                  r_cnt   <= '0;
                  r_state <= ST_ACCUM;
               end else begin
                  r_cnt <= r_cnt + CNTW'(1);
               end
            end
            ST_ACCUM: begin
               r_sum <= r_sum + ACCW'(cal.code);
               if (is_sat_code(cal.code)) begin
                  r_sat <= 1'b1;
               end
               if (r_cnt == ACCUM_LAST) begin
                  r_cnt   <= '0;
                  r_state <= ST_AVG;
               end else begin
                  r_cnt <= r_cnt + CNTW'(1);
               end
            end
            ST_AVG: begin
               if (w_fail) begin
                  r_err   <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_state <= ST_DIV;
               end
            end
            ST_DIV: begin
               if (w_div_valid) begin
                  r_period <= w_avg;
                  r_ktdc   <= w_quot;
                  r_done   <= 1'b1;
                  r_state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign cal.tdc_nrst = r_tdc_nrst;
   assign cal.busy     = r_busy;
   assign cal.done     = r_done;
   assign cal.err      = r_err;
   assign cal.period   = r_period;
   assign cal.ktdc     = r_ktdc;

endmodule

// File: tb/tb_tdc_cal_ctrl.sv
// Directed bench for tdc_cal_ctrl with default parameters; edge numbers are counted
// from the edge that samples START (edge 0).
module tb_tdc_cal_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int edgeNum   = 0;
   int startEdge = 0;
   int compared  = 0;
   int mismatched = 0;
   int codeMode  = 0;
   int codeVal   = 20;
   int satEdge   = -1;

   always #5 clk = ~clk;

   always @(posedge clk) edgeNum++;

   tdc_cal_if #(.FRACW(4), .GAINW(12)) calIf ();

   tdc_cal_ctrl #(
      .LOG2N  (4),
      .SETTLE (8),
      .FRACW  (4),
      .GAINW  (12),
      .MINP   (4)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .cal   (calIf)
   );

   // CODE source: constant, alternating 20/21, or constant with one 63 sample.
   always @(negedge clk) begin
      if (codeMode == 1)
         calIf.code = edgeNum[0] ? 6'd21 : 6'd20;
      else if (codeMode == 2 && edgeNum == satEdge)
         calIf.code = 6'd63;
      else
         calIf.code = 6'(codeVal);
   end

   task automatic start_cal();
      calIf.start = 1'b1;
      startEdge = edgeNum + 1;
      @(negedge clk);
      calIf.start = 1'b0;
   endtask

   task automatic wait_done(output int rel);
      bit seen;
      seen = 1'b0;
      rel = -1;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (calIf.done === 1'b1) begin
            seen = 1'b1;
            rel = edgeNum - startEdge;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      calIf.start = 1'b0;
      codeMode = 0;
      codeVal = 20;
      repeat (2) @(negedge clk);
      compared++; if (calIf.tdc_nrst !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_tdc_nrst: got %0b, expected 0", calIf.tdc_nrst); end
      compared++; if (calIf.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %0b, expected 0", calIf.busy); end
      compared++; if (calIf.done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %0b, expected 0", calIf.done); end
      compared++; if (calIf.err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err: got %0b, expected 0", calIf.err); end
      compared++; if (calIf.period !== 10'd0) begin mismatched++; $display("[TB] FAIL reset_period: got %0d, expected 0", calIf.period); end
      compared++; if (calIf.ktdc !== 12'd0) begin mismatched++; $display("[TB] FAIL reset_ktdc: got %0d, expected 0", calIf.ktdc); end
      rst = 1'b0;
   endtask

   task automatic test_constant();
      int rel;
      codeMode = 0;
      codeVal = 20;
      @(negedge clk);
      start_cal();
      compared++; if (calIf.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL const_busy_edge0: got %0b, expected 0", calIf.busy); end
      @(negedge clk);
      compared++; if (calIf.busy !== 1'b1) begin mismatched++; $display("[TB] FAIL const_busy_edge1: got %0b, expected 1", calIf.busy); end
      compared++; if (calIf.tdc_nrst !== 1'b1) begin mismatched++; $display("[TB] FAIL const_tdc_nrst: got %0b, expected 1", calIf.tdc_nrst); end
      wait_done(rel);
      compared++; if (rel !== 43) begin mismatched++; $display("[TB] FAIL const_done_edge: got %0d, expected 43", rel); end
      compared++; if (calIf.period !== 10'd320) begin mismatched++; $display("[TB] FAIL const_period: got %0d, expected 320", calIf.period); end
      compared++; if (calIf.ktdc !== 12'd204) begin mismatched++; $display("[TB] FAIL const_ktdc: got %0d, expected 204", calIf.ktdc); end
      compared++; if (calIf.err !== 1'b0) begin mismatched++; $display("[TB] FAIL const_err: got %0b, expected 0", calIf.err); end
      @(negedge clk);
      compared++; if (calIf.done !== 1'b0) begin mismatched++; $display("[TB] FAIL const_done_width: got %0b, expected 0", calIf.done); end
      compared++; if (calIf.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL const_busy_fall: got %0b, expected 0", calIf.busy); end
   endtask

   task automatic test_alternate();
      int rel;
      codeMode = 1;
      @(negedge clk);
      start_cal();
      wait_done(rel);
      compared++; if (rel !== 43) begin mismatched++; $display("[TB] FAIL alt_done_edge: got %0d, expected 43", rel); end
      compared++; if (calIf.period !== 10'd328) begin mismatched++; $display("[TB] FAIL alt_period: got %0d, expected 328", calIf.period); end
      compared++; if (calIf.ktdc !== 12'd199) begin mismatched++; $display("[TB] FAIL alt_ktdc: got %0d, expected 199", calIf.ktdc); end
      compared++; if (calIf.err !== 1'b0) begin mismatched++; $display("[TB] FAIL alt_err: got %0b, expected 0", calIf.err); end
      @(negedge clk);
   endtask

   task automatic test_saturation();
      int rel;
      codeMode = 2;
      codeVal = 20;
      @(negedge clk);
      start_cal();
      satEdge = startEdge + 15;
      wait_done(rel);
      compared++; if (rel !== 26) begin mismatched++; $display("[TB] FAIL sat_done_edge: got %0d, expected 26", rel); end
      compared++; if (calIf.err !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_err: got %0b, expected 1", calIf.err); end
      compared++; if (calIf.period !== 10'd328) begin mismatched++; $display("[TB] FAIL sat_period_kept: got %0d, expected 328", calIf.period); end
      compared++; if (calIf.ktdc !== 12'd199) begin mismatched++; $display("[TB] FAIL sat_ktdc_kept: got %0d, expected 199", calIf.ktdc); end
      @(negedge clk);
      codeMode = 0;
   endtask

   task automatic test_min_period();
      int rel;
      codeMode = 0;
      codeVal = 3;
      @(negedge clk);
      start_cal();
      wait_done(rel);
      compared++; if (rel !== 26) begin mismatched++; $display("[TB] FAIL minp_done_edge: got %0d, expected 26", rel); end
      compared++; if (calIf.err !== 1'b1) begin mismatched++; $display("[TB] FAIL minp_err: got %0b, expected 1", calIf.err); end
      @(negedge clk);
      compared++; if (calIf.err !== 1'b1) begin mismatched++; $display("[TB] FAIL minp_err_sticky: got %0b, expected 1", calIf.err); end
      codeVal = 4;
      @(negedge clk);
      start_cal();
      @(negedge clk);
      compared++; if (calIf.err !== 1'b0) begin mismatched++; $display("[TB] FAIL minp_err_clear: got %0b, expected 0", calIf.err); end
      wait_done(rel);
      compared++; if (rel !== 43) begin mismatched++; $display("[TB] FAIL minp4_done_edge: got %0d, expected 43", rel); end
      compared++; if (calIf.period !== 10'd64) begin mismatched++; $display("[TB] FAIL minp4_period: got %0d, expected 64", calIf.period); end
      compared++; if (calIf.ktdc !== 12'd1024) begin mismatched++; $display("[TB] FAIL minp4_ktdc: got %0d, expected 1024", calIf.ktdc); end
      @(negedge clk);
   endtask

   task automatic test_start_ignored();
      int rel;
      int doneCnt;
      int firstDone;
      codeMode = 0;
      codeVal = 20;
      doneCnt = 0;
      firstDone = -1;
      @(negedge clk);
      start_cal();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         rel = edgeNum - startEdge;
         calIf.start = 1'b0;
         if (rel == 15) calIf.start = 1'b1;
         if (calIf.done === 1'b1) begin
            doneCnt++;
            if (firstDone < 0) firstDone = rel;
            calIf.start = 1'b1;
         end
      end
      calIf.start = 1'b0;
      compared++; if (doneCnt !== 1) begin mismatched++; $display("[TB] FAIL ign_done_count: got %0d, expected 1", doneCnt); end
      compared++; if (firstDone !== 43) begin mismatched++; $display("[TB] FAIL ign_done_edge: got %0d, expected 43", firstDone); end
      compared++; if (calIf.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL ign_busy_idle: got %0b, expected 0", calIf.busy); end
      compared++; if (calIf.period !== 10'd320) begin mismatched++; $display("[TB] FAIL ign_period: got %0d, expected 320", calIf.period); end
   endtask

   task automatic test_back_to_back();
      int rel;
      codeMode = 0;
      codeVal = 20;
      @(negedge clk);
      start_cal();
      wait_done(rel);
      compared++; if (rel !== 43) begin mismatched++; $display("[TB] FAIL b2b_first_done_edge: got %0d, expected 43", rel); end
      @(negedge clk);
      compared++; if (calIf.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_busy_gap: got %0b, expected 0", calIf.busy); end
      codeVal = 21;
      start_cal();
      @(negedge clk);
      compared++; if (calIf.busy !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_accepted: got %0b, expected 1", calIf.busy); end
      wait_done(rel);
      compared++; if (rel !== 43) begin mismatched++; $display("[TB] FAIL b2b_done_edge: got %0d, expected 43", rel); end
      compared++; if (calIf.period !== 10'd336) begin mismatched++; $display("[TB] FAIL b2b_period: got %0d, expected 336", calIf.period); end
      compared++; if (calIf.ktdc !== 12'd195) begin mismatched++; $display("[TB] FAIL b2b_ktdc: got %0d, expected 195", calIf.ktdc); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_div();
      int rel;
      codeMode = 0;
      codeVal = 20;
      @(negedge clk);
      start_cal();
      repeat (29) @(negedge clk);
      rst = 1'b1;
      #1;
      compared++; if (calIf.tdc_nrst !== 1'b0) begin mismatched++; $display("[TB] FAIL rdiv_tdc_nrst: got %0b, expected 0", calIf.tdc_nrst); end
      compared++; if (calIf.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rdiv_busy: got %0b, expected 0", calIf.busy); end
      compared++; if (calIf.done !== 1'b0) begin mismatched++; $display("[TB] FAIL rdiv_done: got %0b, expected 0", calIf.done); end
      compared++; if (calIf.err !== 1'b0) begin mismatched++; $display("[TB] FAIL rdiv_err: got %0b, expected 0", calIf.err); end
      compared++; if (calIf.period !== 10'd0) begin mismatched++; $display("[TB] FAIL rdiv_period: got %0d, expected 0", calIf.period); end
      compared++; if (calIf.ktdc !== 12'd0) begin mismatched++; $display("[TB] FAIL rdiv_ktdc: got %0d, expected 0", calIf.ktdc); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      start_cal();
      @(negedge clk);
      compared++; if (calIf.tdc_nrst !== 1'b1) begin mismatched++; $display("[TB] FAIL rdiv_rerun_nrst: got %0b, expected 1", calIf.tdc_nrst); end
      wait_done(rel);
      compared++; if (rel !== 43) begin mismatched++; $display("[TB] FAIL rdiv_rerun_done_edge: got %0d, expected 43", rel); end
      compared++; if (calIf.period !== 10'd320) begin mismatched++; $display("[TB] FAIL rdiv_rerun_period: got %0d, expected 320", calIf.period); end
      compared++; if (calIf.ktdc !== 12'd204) begin mismatched++; $display("[TB] FAIL rdiv_rerun_ktdc: got %0d, expected 204", calIf.ktdc); end
      compared++; if (calIf.err !== 1'b0) begin mismatched++; $display("[TB] FAIL rdiv_rerun_err: got %0b, expected 0", calIf.err); end
      @(negedge clk);
   endtask

   initial begin
      calIf.start = 1'b0;
      $display("[TB] tdc_cal_ctrl directed tests starting");
      test_reset();
      test_constant();
      test_alternate();
      test_saturation();
      test_min_period();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid_div();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
